ram_wide_drain: RTL and testbench

//  Reader side of ram_wide: once the multichannel RAM reports full (or on start), reads

---
 rtl/ram_wide_drain.sv | 131 +++++++++++++
 tb/tb_ram_wide_drain.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_wide_drain.sv
// Reader side of ram_wide: on start or a rising ram_full, reads every RAM word in
// address order and streams it MSB byte first over valid/ready, after one header byte.
module ram_wide_drain #(
  parameter int          NUM_CHANNELS = 4,
  parameter int          DATA_WIDTH   = 16,
  parameter int          ADDR_WIDTH   = 4,
  parameter int          NUM_WORDS    = 9,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               ram_full,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ram_data,
  output logic                               ram_read_en,
  output logic [ADDR_WIDTH-1:0]              ram_addr,
  output logic [7:0]                         tx_data,
  output logic                               tx_valid,
  input  logic                               tx_ready,
  output logic                               busy,
  output logic                               done
);

  localparam int TOTAL_WIDTH = NUM_CHANNELS * DATA_WIDTH;
  localparam int BPW         = TOTAL_WIDTH / 8;
  localparam int CNT_W       = $clog2(BPW + 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD,
    LAT,
    SEND,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [TOTAL_WIDTH-1:0]  shift_q, shift_d;
  logic                    ram_full_q;
  logic                    trig;

  logic                    tx_valid_q, tx_valid_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    ram_read_en_q, ram_read_en_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  assign trig = start | (ram_full & ~ram_full_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: if (trig) begin
        state_d = HDR;
        idx_d   = '0;
      end
      HDR:  if (tx_valid_q && tx_ready) state_d = RD;
      RD:   state_d = LAT;
      LAT: begin
        shift_d = ram_data;
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: if (tx_valid_q && tx_ready) begin
        shift_d = shift_q << 8;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BPW - 1)) begin
          if (idx_q == ADDR_WIDTH'(NUM_WORDS - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            state_d = RD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    tx_valid_d    = (state_d == HDR) || (state_d == SEND);
    tx_data_d     = (state_d == HDR)  ? HEADER :
                    (state_d == SEND) ? shift_d[TOTAL_WIDTH-1 -: 8] : '0;
    ram_read_en_d = (state_d == RD);
    ram_addr_d    = (state_d == RD) ? idx_d : ram_addr_q;
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      shift_q       <= '0;
      ram_full_q    <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      ram_read_en_q <= 1'b0;
      ram_addr_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      ram_full_q    <= ram_full;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      ram_read_en_q <= ram_read_en_d;
      ram_addr_q    <= ram_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign ram_read_en = ram_read_en_q;
  assign ram_addr    = ram_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ram_wide_drain.sv
// Directed/randomised bench for ram_wide_drain with a 1-cycle sync-read RAM model
// and a byte-stream reference built directly from the RAM contents.
module tb_ram_wide_drain;
  localparam int         NC  = 4;
  localparam int         DW  = 16;
  localparam int         AW  = 4;
  localparam int         NW  = 9;
  localparam int         TW  = NC * DW;
  localparam int         BPW = TW / 8;
  localparam int         FRAME_LEN = 1 + NW * BPW;
  localparam logic [7:0] HDRB = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          ram_full = 1'b0;
  logic [TW-1:0] ram_data = '0;
  logic          ram_read_en;
  logic [AW-1:0] ram_addr;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;

  logic [TW-1:0] mem [2**AW];
  logic [7:0]    got[$];
  logic [7:0]    expq[$];
  int            rd_addr[$];
  int            done_cnt = 0;
  bit            rnd_ready = 1'b0;
  bit            prev_stall = 1'b0;
  logic [7:0]    prev_data = '0;

  ram_wide_drain #(
    .NUM_CHANNELS(NC),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .NUM_WORDS   (NW),
    .HEADER      (HDRB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ram_full   (ram_full),
    .ram_data   (ram_data),
    .ram_read_en(ram_read_en),
    .ram_addr   (ram_addr),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // ram_wide behaviour: data appears the cycle after read_en/addr are sampled.
  always @(posedge clk) if (ram_read_en) ram_data <= mem[ram_addr];

  always @(posedge clk) begin
    #1;
    tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_valid", 64'(tx_valid), 64'd1);
        check("stall_data", 64'(tx_data), 64'(prev_data));
      end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (ram_read_en) rd_addr.push_back(int'(ram_addr));
      if (done) done_cnt++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic build_exp();
    expq = {};
    expq.push_back(HDRB);
    for (int w = 0; w < NW; w++)
      for (int b = 0; b < BPW; b++)
        expq.push_back(8'(mem[w] >> (TW - 8 - 8 * b)));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_timeout"}, 64'(n < 3000), 64'd1);
    @(negedge clk); #1;
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, 64'(got.size()), 64'(FRAME_LEN));
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 64'(got[i]), 64'(expq[i]));
  endtask

  initial begin
    int d0;
    int n;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_read_en", 64'(ram_read_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Counting pattern, full-rate sink
    for (int i = 0; i < NW; i++) mem[i] = {4{16'(i + 1)}};
    build_exp();
    got = {}; rd_addr = {}; d0 = done_cnt;
    pulse_start();
    wait_done("cnt");
    compare_frame("cnt");
    check("cnt_first_hdr", 64'(got[0]), 64'hA5);
    check("cnt_byte1", 64'(got[1]), 64'h00);
    check("cnt_byte2", 64'(got[2]), 64'h01);
    check("cnt_last", 64'(got[FRAME_LEN-1]), 64'h09);
    check("cnt_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("rd_count", 64'(rd_addr.size()), 64'(NW));
    for (int i = 0; i < rd_addr.size(); i++)
      check($sformatf("rd_addr%0d", i), 64'(rd_addr[i]), 64'(i));

    // Random data with random backpressure
    for (int i = 0; i < NW; i++) mem[i] = {$urandom, $urandom};
    build_exp();
    rnd_ready = 1'b1;
    got = {}; d0 = done_cnt;
    pulse_start();
    wait_done("bp");
    compare_frame("bp");
    check("bp_done_pulses", 64'(done_cnt - d0), 64'd1);
    rnd_ready = 1'b0;

    // ram_full rising edge triggers; held level does not retrigger
    for (int i = 0; i < NW; i++) mem[i] = {$urandom, $urandom};
    build_exp();
    got = {}; d0 = done_cnt;
    @(posedge clk); #1;
    ram_full = 1'b1;
    wait_done("full");
    compare_frame("full");
    repeat (60) @(negedge clk);
    #1;
    check("full_no_retrig_bytes", 64'(got.size()), 64'(FRAME_LEN));
    check("full_no_retrig_done", 64'(done_cnt - d0), 64'd1);
    check("full_no_retrig_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    ram_full = 1'b0;
    repeat (3) @(posedge clk);

    // start while busy is dropped
    for (int i = 0; i < NW; i++) mem[i] = {$urandom, $urandom};
    build_exp();
    got = {}; d0 = done_cnt;
    pulse_start();
    n = 0;
    while (got.size() < 5 && n < 200) begin @(negedge clk); n++; end
    check("busy_start_reach_send", 64'(n < 200), 64'd1);
    pulse_start();
    wait_done("busy_start");
    repeat (60) @(negedge clk);
    #1;
    compare_frame("busy_start");
    check("busy_start_done", 64'(done_cnt - d0), 64'd1);

    // Reset in the middle of a SEND phase
    got = {};
    pulse_start();
    n = 0;
    while (got.size() < 4 && n < 200) begin @(negedge clk); n++; end
    check("mid_rst_reach_send", 64'(n < 200), 64'd1);
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
    check("mid_rst_read_en", 64'(ram_read_en), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
    check("mid_rst_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
